// File: rtl/dp_inst_buffer_pkg.sv
// Shared types and default sizing for the dispatch instruction buffer.
package dp_inst_buffer_pkg;

   localparam int unsigned DPBUF_WIDTH = 3;
   localparam int unsigned DPBUF_DEPTH = 8;

   // IF/ID pipeline register payload; valid marks a live fetch slot
   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] npc;
      logic [31:0] pc;
   } if_id_packet_t;

endpackage

// File: rtl/dp_inst_buffer_if.sv
// Fetch-side and dispatch-side bundle of the instruction buffer.
interface dp_inst_buffer_if
   import dp_inst_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = DPBUF_WIDTH,
   parameter int unsigned DEPTH = DPBUF_DEPTH
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned LIM_W = $clog2(WIDTH + 1);

   logic                         squash;
   if_id_packet_t [WIDTH-1:0]    in_packet;
   logic                         in_stall;
   logic [LIM_W-1:0]             dp_limit;
   if_id_packet_t [WIDTH-1:0]    out_packet;
   logic [WIDTH-1:0]             out_valid;
   logic [CNT_W-1:0]             count;

   modport master (
      output squash, in_packet, dp_limit,
      input  in_stall, out_packet, out_valid, count
   );

   modport slave (
      input  squash, in_packet, dp_limit,
      output in_stall, out_packet, out_valid, count
   );

endinterface

// File: rtl/dp_compact.sv
// Maps sparse valid slots to dense output positions, ascending slot order.
module dp_compact #(
   parameter  int unsigned WIDTH = 3,
   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int unsigned LIM_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]            valid,
   output logic [WIDTH-1:0][IDX_W-1:0] src_idx,
   output logic [LIM_W-1:0]            cnt
);

   always_comb begin
      src_idx = '0;
      cnt     = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (valid[j]) begin
            src_idx[cnt] = IDX_W'(j);
            cnt          = cnt + LIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/dp_inst_buffer.sv
// In-order N-wide instruction queue between IF/ID and dispatch, credit-limited show-ahead pop.
// Define DPBUF_BYPASS_EN to forward incoming slots straight to the output when empty.
module dp_inst_buffer
   import dp_inst_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = DPBUF_WIDTH,
   parameter int unsigned DEPTH = DPBUF_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   dp_inst_buffer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned LIM_W = $clog2(WIDTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if_id_packet_t               mem [DEPTH];
   logic [PTR_W-1:0]            head;
   logic [PTR_W-1:0]            tail;
   logic [CNT_W-1:0]            cnt_q;

   logic [WIDTH-1:0]            in_valid;
   logic [WIDTH-1:0][IDX_W-1:0] src_idx;
   logic [LIM_W-1:0]            push_cnt;
   logic [LIM_W-1:0]            lim;
   logic [LIM_W-1:0]            n_out;
   logic [LIM_W-1:0]            skip;
   logic [LIM_W-1:0]            wr_n;
   logic [LIM_W-1:0]            pop_n;
   logic                        stall;
   logic                        push_en;
`ifdef DPBUF_BYPASS_EN
   logic                        byp_act;
`endif

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         in_valid[i] = bus.in_packet[i].valid;
      end
   end

   dp_compact #(.WIDTH(WIDTH)) u_compact (
      .valid   (in_valid),
      .src_idx (src_idx),
      .cnt     (push_cnt)
   );

   // Push/pop accounting; free space is judged on start-of-cycle occupancy
   always_comb begin
      stall   = (CNT_W'(DEPTH) - cnt_q) < CNT_W'(WIDTH);
      push_en = !stall && !bus.squash;
      lim     = (bus.dp_limit > LIM_W'(WIDTH)) ? LIM_W'(WIDTH) : bus.dp_limit;
      n_out   = (cnt_q < CNT_W'(lim)) ? LIM_W'(cnt_q) : lim;
      skip    = '0;
      pop_n   = bus.squash ? '0 : n_out;
`ifdef DPBUF_BYPASS_EN
      byp_act = (cnt_q == '0) && !bus.squash;
      if (byp_act) begin
         n_out = (push_cnt < lim) ? push_cnt : lim;
         skip  = n_out;
         pop_n = '0;
      end
`endif
      wr_n    = push_en ? (push_cnt - skip) : '0;
   end

   // Show-ahead output; squash hides everything for the cycle
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         bus.out_packet[i] = mem[head + PTR_W'(i)];
         bus.out_valid[i]  = !bus.squash && (LIM_W'(i) < n_out);
`ifdef DPBUF_BYPASS_EN
         if (byp_act) begin
            bus.out_packet[i] = bus.in_packet[src_idx[i]];
         end
`endif
      end
      bus.in_stall = stall;
      bus.count    = cnt_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
      end else if (bus.squash) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(wr_n);
         cnt_q <= cnt_q + CNT_W'(wr_n) - CNT_W'(pop_n);
      end
   end

   // Entry storage is left unreset; out_valid masks anything stale
   always_ff @(posedge clock) begin
      if (push_en) begin
         for (int k = 0; k < WIDTH; k++) begin
            if ((LIM_W'(k) >= skip) && (LIM_W'(k) < push_cnt)) begin
               mem[tail + PTR_W'(LIM_W'(k) - skip)] <= bus.in_packet[src_idx[k]];
            end
         end
      end
   end

endmodule
